// File: rtl/uart_cfg_regfile_mc.sv
// Multi-channel UART configuration register file.
// Per-channel CTRL/BAUD/STATUS/SCRATCH with shadowed baud commit.
module uart_cfg_regfile_mc #(
  parameter int N_CH         = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 0,
  parameter int BAUD_RST     = 9600,
  parameter int ADDR_WIDTH   = $clog2(N_CH*4)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b,
  output logic                  wr_err,
  input  logic [N_CH-1:0]       uart_busy,
  input  logic [N_CH-1:0]       uart_error,
  output logic [N_CH-1:0]       uart_enable,
  output logic [3*N_CH-1:0]     uart_mode,
  output logic [16*N_CH-1:0]    uart_rate,
  output logic [N_CH-1:0]       update_ok
);

  localparam int CW = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(N_CH*4);
  localparam logic [15:0] BRST = 16'(BAUD_RST);

  logic [3:0]            ctrl_q    [N_CH];
  logic [3:0]            ctrl_d    [N_CH];
  logic [15:0]           shadow_q  [N_CH];
  logic [15:0]           shadow_d  [N_CH];
  logic [15:0]           rate_q    [N_CH];
  logic [15:0]           rate_d    [N_CH];
  logic [DATA_WIDTH-1:0] scratch_q [N_CH];
  logic [DATA_WIDTH-1:0] scratch_d [N_CH];
  logic [N_CH-1:0]       pend_q, pend_d;
  logic [N_CH-1:0]       err_q, err_d;
  logic [N_CH-1:0]       upd_q, upd_d;
  logic                  wr_err_q, wr_err_d;

  logic [CW-1:0]   wr_ch;
  logic [1:0]      wr_reg;
  logic            wr_in;
  logic            wr_rej;
  logic            wr_ok;
  logic [N_CH-1:0] wr_hit;

  assign wr_ch  = wr_addr[ADDR_WIDTH-1:2];
  assign wr_reg = wr_addr[1:0];
  assign wr_in  = wr_addr < LIMIT;
  assign wr_rej = (wr_reg == 2'd1 && wr_data[15:0] == 16'd0) ||
                  (wr_reg == 2'd0 && wr_data[3:1] > 3'd4);
  assign wr_ok  = wr_en && wr_in && !wr_rej;

  // Decode the accepted write into a one-hot channel select
  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < N_CH; c++)
      wr_hit[c] = wr_ok && (wr_ch == CW'(c));
  end

  // Next state: commit first, then write, then sticky error set
  always_comb begin
    wr_err_d = wr_en && (!wr_in || wr_rej);
    pend_d   = pend_q;
    err_d    = err_q;
    upd_d    = '0;
    for (int c = 0; c < N_CH; c++) begin
      ctrl_d[c]    = ctrl_q[c];
      shadow_d[c]  = shadow_q[c];
      rate_d[c]    = rate_q[c];
      scratch_d[c] = scratch_q[c];
      if (pend_q[c] && !uart_busy[c]) begin
        rate_d[c] = shadow_q[c];
        pend_d[c] = 1'b0;
        upd_d[c]  = 1'b1;
      end
      if (wr_hit[c]) begin
        case (wr_reg)
          2'd0: ctrl_d[c] = wr_data[3:0];
          2'd1: begin
            shadow_d[c] = wr_data[15:0];
            pend_d[c]   = 1'b1;
          end
          2'd2: if (wr_data[1]) err_d[c] = 1'b0;
          default: scratch_d[c] = wr_data;
        endcase
      end
      if (uart_error[c]) err_d[c] = 1'b1;
    end
  end

  // Register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '{default: '0};
      shadow_q  <= '{default: BRST};
      rate_q    <= '{default: BRST};
      scratch_q <= '{default: '0};
      pend_q    <= '0;
      err_q     <= '0;
      upd_q     <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      rate_q    <= rate_d;
      scratch_q <= scratch_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // BAUD reads return the shadow; same-address accepted writes bypass
  // except STATUS, whose write value is not its read value
  function automatic logic [DATA_WIDTH-1:0] reg_rd(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (a[ADDR_WIDTH-1:2] == CW'(c)) begin
        case (a[1:0])
          2'd0: v = DATA_WIDTH'(ctrl_q[c]);
          2'd1: v = DATA_WIDTH'(shadow_q[c]);
          2'd2: v = DATA_WIDTH'({pend_q[c], err_q[c], uart_busy[c]});
          default: v = scratch_q[c];
        endcase
      end
    end
    if (wr_ok && wr_addr == a && wr_reg != 2'd2) v = wr_data;
    return v;
  endfunction

  logic                  rd_valid_a_d, rd_valid_b_d;
  logic [DATA_WIDTH-1:0] rd_data_a_d, rd_data_b_d;

  // Read ports: data forced to zero when not valid
  always_comb begin
    rd_valid_a_d = rd_en_a && (rd_addr_a < LIMIT);
    rd_valid_b_d = rd_en_b && (rd_addr_b < LIMIT);
    rd_data_a_d  = rd_valid_a_d ? reg_rd(rd_addr_a) : '0;
    rd_data_b_d  = rd_valid_b_d ? reg_rd(rd_addr_b) : '0;
  end

  if (READ_LATENCY == 0) begin : g_rd_comb
    assign rd_valid_a = rd_valid_a_d;
    assign rd_valid_b = rd_valid_b_d;
    assign rd_data_a  = rd_data_a_d;
    assign rd_data_b  = rd_data_b_d;
  end else begin : g_rd_reg
    logic                  rd_valid_a_q, rd_valid_b_q;
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_b_q;
    // Registered read, write-first via the bypass above
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_a_q <= 1'b0;
        rd_valid_b_q <= 1'b0;
        rd_data_a_q  <= '0;
        rd_data_b_q  <= '0;
      end else begin
        rd_valid_a_q <= rd_valid_a_d;
        rd_valid_b_q <= rd_valid_b_d;
        rd_data_a_q  <= rd_data_a_d;
        rd_data_b_q  <= rd_data_b_d;
      end
    end
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
  end

  // Flatten per-channel state onto the UART-array ports
  always_comb begin
    uart_enable = '0;
    uart_mode   = '0;
    uart_rate   = '0;
    for (int c = 0; c < N_CH; c++) begin
      uart_enable[c]      = ctrl_q[c][0];
      uart_mode[3*c +: 3] = ctrl_q[c][3:1];
      uart_rate[16*c +: 16] = rate_q[c];
    end
  end

  assign update_ok = upd_q;
  assign wr_err    = wr_err_q;

endmodule
